// File: rtl/soc_bus_pkg.sv
// Shared definitions for the two-master SoC bus arbiter.
// State encoding, the read data returned on a forced timeout, and master index helpers.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } bus_state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic other_master(input logic m);
    return ~m;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the priority pointer moves to the other master
// whenever a transaction completes.
module rr_arbiter2
  import soc_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last_grant,
  output logic       pick
);

  logic ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= M0;
    end else if (advance) begin
      ptr <= other_master(last_grant);
    end
  end

  always_comb begin
    pick = ptr;
    if (!req[ptr] && req[other_master(ptr)]) begin
      pick = other_master(ptr);
    end
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Two-master round-robin arbiter for the shared SoC memory/peripheral bus.
// Optional WAIT timeout is enabled by defining SOC_BUS_ARB_TIMEOUT_EN.
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  input  logic                m0_rstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rbusy,
  output logic                m0_wbusy,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  input  logic                m1_rstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rbusy,
  output logic                m1_wbusy,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  output logic                s_rstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rbusy,
  input  logic                s_wbusy,
  output logic                grant,
  output logic                err_timeout
);

  localparam int MASK_W = DATA_W / 8;

  logic [1:0][ADDR_W-1:0] in_addr, pend_addr, eff_addr;
  logic [1:0][DATA_W-1:0] in_wdata, pend_wdata, eff_wdata, rdata_q;
  logic [1:0][MASK_W-1:0] in_wmask, pend_wmask, eff_wmask;
  logic [1:0]             in_rstrb, pend_valid, pend_write, new_req, req_eff, eff_write;

  bus_state_t state, state_next;
  logic       slave_done, timeout_hit, complete, launch, launch_idx, rr_pick;

  assign in_addr  = {m1_addr, m0_addr};
  assign in_wdata = {m1_wdata, m0_wdata};
  assign in_wmask = {m1_wmask, m0_wmask};
  assign in_rstrb = {m1_rstrb, m0_rstrb};

  // A strobe can be issued in the same cycle it arrives, so arbitration sees
  // both latched requests and fresh strobes from idle masters.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      new_req[i]   = ((in_wmask[i] != '0) || in_rstrb[i]) && !pend_valid[i];
      req_eff[i]   = pend_valid[i] || new_req[i];
      eff_addr[i]  = pend_valid[i] ? pend_addr[i]  : in_addr[i];
      eff_wdata[i] = pend_valid[i] ? pend_wdata[i] : in_wdata[i];
      eff_wmask[i] = pend_valid[i] ? pend_wmask[i] : in_wmask[i];
      eff_write[i] = pend_valid[i] ? pend_write[i] : (in_wmask[i] != '0);
    end
  end

  assign slave_done = pend_write[grant] ? !s_wbusy : !s_rbusy;
  assign complete   = (state == ST_WAIT) && (slave_done || timeout_hit);

  rr_arbiter2 u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req_eff),
    .advance    (complete),
    .last_grant (grant),
    .pick       (rr_pick)
  );

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    launch_idx = rr_pick;
    unique case (state)
      ST_IDLE: begin
        if (|req_eff) begin
          launch     = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (complete) begin
          launch_idx = other_master(grant);
          launch     = req_eff[launch_idx];
          state_next = launch ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      pend_valid <= '0;
      pend_write <= '0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      pend_wmask <= '0;
    end else begin
      state <= state_next;
      for (int i = 0; i < 2; i++) begin
        if (complete && (grant == 1'(i))) begin
          pend_valid[i] <= 1'b0;
        end else if (new_req[i]) begin
          pend_valid[i] <= 1'b1;
          pend_write[i] <= (in_wmask[i] != '0);
          pend_addr[i]  <= in_addr[i];
          pend_wdata[i] <= in_wdata[i];
          pend_wmask[i] <= in_wmask[i];
        end
      end
    end
  end

  // Slave address/data hold their last values; strobes only pulse in ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_addr  <= '0;
      s_wdata <= '0;
      s_wmask <= '0;
      s_rstrb <= 1'b0;
      grant   <= M0;
      rdata_q <= '0;
    end else begin
      s_wmask <= '0;
      s_rstrb <= 1'b0;
      if (launch) begin
        grant   <= launch_idx;
        s_addr  <= eff_addr[launch_idx];
        s_wdata <= eff_wdata[launch_idx];
        if (eff_write[launch_idx]) begin
          s_wmask <= eff_wmask[launch_idx];
        end else begin
          s_rstrb <= 1'b1;
        end
      end
      if (complete && !pend_write[grant]) begin
        rdata_q[grant] <= timeout_hit ? DATA_W'(TIMEOUT_RDATA) : s_rdata;
      end
    end
  end

`ifdef SOC_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= complete && timeout_hit;
      if (state != ST_WAIT) begin
        wait_cnt <= '0;
      end else if (!slave_done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign timeout_hit = (state == ST_WAIT) && !slave_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign m0_rdata = rdata_q[M0];
  assign m1_rdata = rdata_q[M1];
  assign m0_rbusy = pend_valid[M0] && !pend_write[M0];
  assign m0_wbusy = pend_valid[M0] &&  pend_write[M0];
  assign m1_rbusy = pend_valid[M1] && !pend_write[M1];
  assign m1_wbusy = pend_valid[M1] &&  pend_write[M1];

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed self-checking bench for soc_bus_arbiter with a registered-read slave model.
// The timeout scenario follows SOC_BUS_ARB_TIMEOUT_EN.
module tb_soc_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_rstrb = 1'b0, m1_rstrb = 1'b0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata = '0;
  logic [3:0]  s_wmask;
  logic        s_rstrb;
  logic        s_rbusy = 1'b0, s_wbusy = 1'b0;
  logic        grant, err_timeout;

  int tests_run = 0;
  int tests_failed = 0;
  int rstrb_count = 0;
  int wmask_count = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  logic [3:0]  last_wmask = '0;
  logic        issue_log[$];

  always #5 clk = ~clk;

  soc_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
    .grant(grant), .err_timeout(err_timeout)
  );

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return a ^ 32'h1234_5668;
  endfunction

  // Registered-read slave: data for a strobe appears in the following cycle.
  always @(posedge clk) begin
    if (s_rstrb) begin
      s_rdata <= slave_data(s_addr);
      rstrb_count++;
      issue_log.push_back(grant);
    end
    if (s_wmask != 4'b0) begin
      last_waddr <= s_addr;
      last_wdata <= s_wdata;
      last_wmask <= s_wmask;
      wmask_count++;
      issue_log.push_back(grant);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m0_rstrb = 1'b0; m1_rstrb = 1'b0; m0_wmask = '0; m1_wmask = '0;
    s_rbusy = 1'b0; s_wbusy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    issue_log.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy} !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy: got %b expected 0000", {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy});
    end
    tests_run++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata);
    end
    tests_run++;
    if ({s_addr, s_wdata, s_wmask, s_rstrb, grant, err_timeout} !== 71'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_slave: got addr %h wdata %h wmask %b rstrb %b grant %b err %b expected all 0",
               s_addr, s_wdata, s_wmask, s_rstrb, grant, err_timeout);
    end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    int base_r;
    base_r = rstrb_count;
    tick(); m0_addr = 32'h10; m0_rstrb = 1'b1;
    @(negedge clk);
    tests_run++;
    if (m0_rbusy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL single_busy_N: got %b expected 0", m0_rbusy);
    end
    tick(); m0_rstrb = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({m0_rbusy, s_rstrb, grant, s_addr} !== {1'b1, 1'b1, 1'b0, 32'h10}) begin
      tests_failed++;
      $display("[TB] FAIL single_issue_N1: got rbusy %b rstrb %b grant %b addr %h expected 1 1 0 00000010",
               m0_rbusy, s_rstrb, grant, s_addr);
    end
    tick(); @(negedge clk);
    tests_run++;
    if ({m0_rbusy, s_rstrb} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL single_wait_N2: got rbusy %b rstrb %b expected 1 0", m0_rbusy, s_rstrb);
    end
    tick(); @(negedge clk);
    tests_run++;
    if ({m0_rbusy, m0_rdata} !== {1'b0, 32'h1234_5678}) begin
      tests_failed++; $display("[TB] FAIL single_done_N3: got rbusy %b rdata %h expected 0 12345678", m0_rbusy, m0_rdata);
    end
    tests_run++;
    if (rstrb_count - base_r !== 1) begin
      tests_failed++; $display("[TB] FAIL single_strobe_count: got %0d expected 1", rstrb_count - base_r);
    end
  endtask

  task automatic test_simultaneous();
    tick(); m0_addr = 32'h10; m1_addr = 32'h20; m0_rstrb = 1'b1; m1_rstrb = 1'b1;
    tick(); m0_rstrb = 1'b0; m1_rstrb = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({s_rstrb, grant, s_addr, m1_rbusy} !== {1'b1, 1'b0, 32'h10, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL simul_first_issue: got rstrb %b grant %b addr %h m1_rbusy %b expected 1 0 00000010 1",
               s_rstrb, grant, s_addr, m1_rbusy);
    end
    tick(); tick(); @(negedge clk);
    tests_run++;
    if ({s_rstrb, grant, s_addr, m0_rbusy, m0_rdata} !== {1'b1, 1'b1, 32'h20, 1'b0, 32'h1234_5678}) begin
      tests_failed++;
      $display("[TB] FAIL simul_second_issue: got rstrb %b grant %b addr %h m0_rbusy %b m0_rdata %h expected 1 1 00000020 0 12345678",
               s_rstrb, grant, s_addr, m0_rbusy, m0_rdata);
    end
    tick(); @(negedge clk);
    tests_run++;
    if (m1_rbusy !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL simul_m1_busy_N4: got %b expected 1", m1_rbusy);
    end
    tick(); @(negedge clk);
    tests_run++;
    if ({m1_rbusy, m1_rdata} !== {1'b0, 32'h1234_5648}) begin
      tests_failed++; $display("[TB] FAIL simul_m1_done_N5: got rbusy %b rdata %h expected 0 12345648", m1_rbusy, m1_rdata);
    end
  endtask

  task automatic test_write_stall();
    int base_w;
    base_w = wmask_count;
    tick(); m1_addr = 32'h400; m1_wdata = 32'hA5; m1_wmask = 4'b0001; s_wbusy = 1'b1;
    tick(); m1_wmask = 4'b0000;
    @(negedge clk);
    tests_run++;
    if ({s_wmask, s_wdata, s_addr, grant, m1_wbusy, m1_rbusy} !== {4'b0001, 32'hA5, 32'h400, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL write_issue: got wmask %b wdata %h addr %h grant %b wbusy %b rbusy %b expected 0001 000000a5 00000400 1 1 0",
               s_wmask, s_wdata, s_addr, grant, m1_wbusy, m1_rbusy);
    end
    tick(); tick(); tick();
    s_wbusy = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m1_wbusy !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL write_busy_N5: got %b expected 1", m1_wbusy);
    end
    tick(); @(negedge clk);
    tests_run++;
    if ({m1_wbusy, s_wmask, s_addr, s_wdata} !== {1'b0, 4'b0, 32'h400, 32'hA5}) begin
      tests_failed++;
      $display("[TB] FAIL write_done_N6: got wbusy %b wmask %b addr %h wdata %h expected 0 0000 00000400 000000a5",
               m1_wbusy, s_wmask, s_addr, s_wdata);
    end
    tests_run++;
    if ({wmask_count - base_w, last_waddr, last_wdata, last_wmask} !== {32'd1, 32'h400, 32'hA5, 4'b0001}) begin
      tests_failed++;
      $display("[TB] FAIL write_slave_log: got pulses %0d addr %h data %h mask %b expected 1 00000400 000000a5 0001",
               wmask_count - base_w, last_waddr, last_wdata, last_wmask);
    end
  endtask

  task automatic test_alternation();
    int issued0 = 0;
    int issued1 = 0;
    int cycles = 0;
    issue_log.delete();
    while (issue_log.size() < 20 && cycles < 300) begin
      tick(); cycles++;
      m0_rstrb = 1'b0; m1_wmask = 4'b0;
      if (!m0_rbusy && issued0 < 10) begin
        m0_addr = 32'h100 + 32'(issued0 * 4); m0_rstrb = 1'b1; issued0++;
      end
      if (!m1_wbusy && issued1 < 10) begin
        m1_addr = 32'h200 + 32'(issued1 * 4); m1_wdata = 32'hC0DE_0000 + 32'(issued1);
        m1_wmask = 4'hF; issued1++;
      end
    end
    tick(); m0_rstrb = 1'b0; m1_wmask = 4'b0;
    cycles = 0;
    while ((m0_rbusy || m1_wbusy) && cycles < 20) begin
      tick(); cycles++;
    end
    @(negedge clk);
    tests_run++;
    if (issue_log.size() !== 20 || m0_rbusy || m1_wbusy) begin
      tests_failed++;
      $display("[TB] FAIL alt_count: got %0d issues busy %b%b expected 20 issues idle", issue_log.size(), m0_rbusy, m1_wbusy);
    end
    if (issue_log.size() > 0) begin
      tests_run++;
      if (issue_log[0] !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL alt_first: got grant %b expected 0", issue_log[0]);
      end
    end
    for (int k = 1; k < issue_log.size(); k++) begin
      tests_run++;
      if (issue_log[k] === issue_log[k-1]) begin
        tests_failed++; $display("[TB] FAIL alt_order_%0d: got grant %b after %b expected alternation", k, issue_log[k], issue_log[k-1]);
      end
    end
    tests_run++;
    if ({m0_rdata, last_wdata, last_waddr} !== {32'h1234_574C, 32'hC0DE_0009, 32'h224}) begin
      tests_failed++;
      $display("[TB] FAIL alt_last_data: got rdata %h wdata %h waddr %h expected 1234574c c0de0009 00000224",
               m0_rdata, last_wdata, last_waddr);
    end
  endtask

  task automatic test_reset_in_wait();
    int base_r;
    s_rbusy = 1'b1;
    tick(); m0_addr = 32'h40; m0_rstrb = 1'b1;
    tick(); m0_rstrb = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, s_rstrb, grant} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_wait_immediate: got busy %b%b%b%b rstrb %b grant %b expected all 0",
               m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, s_rstrb, grant);
    end
    base_r = rstrb_count;
    tick(); tick();
    reset_n = 1'b1; s_rbusy = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (rstrb_count !== base_r || m0_rbusy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_wait_quiet: got %0d strobes m0_rbusy %b expected 0 strobes busy 0", rstrb_count - base_r, m0_rbusy);
    end
    m1_addr = 32'h30; m1_rstrb = 1'b1;
    tick(); m1_rstrb = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({s_rstrb, grant, s_addr} !== {1'b1, 1'b1, 32'h30}) begin
      tests_failed++;
      $display("[TB] FAIL rst_wait_reissue: got rstrb %b grant %b addr %h expected 1 1 00000030", s_rstrb, grant, s_addr);
    end
    tick(); tick(); @(negedge clk);
    tests_run++;
    if ({m1_rbusy, m1_rdata} !== {1'b0, 32'h1234_5658}) begin
      tests_failed++; $display("[TB] FAIL rst_wait_after: got rbusy %b rdata %h expected 0 12345658", m1_rbusy, m1_rdata);
    end
  endtask

  task automatic test_timeout();
    logic bad;
    bad = 1'b0;
    s_rbusy = 1'b1;
    tick(); m0_addr = 32'h50; m0_rstrb = 1'b1;
    tick(); m0_rstrb = 1'b0; m1_addr = 32'h60; m1_rstrb = 1'b1;
    tick(); m1_rstrb = 1'b0;
`ifdef SOC_BUS_ARB_TIMEOUT_EN
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      if (err_timeout !== 1'b0 || m0_rbusy !== 1'b1) bad = 1'b1;
      if (k < 9) tick();
    end
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL timeout_early: got early completion or pulse expected none before 8 cycles");
    end
    tick(); s_rbusy = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({err_timeout, m0_rbusy, m0_rdata, s_rstrb, grant} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL timeout_fire: got err %b rbusy %b rdata %h rstrb %b grant %b expected 1 0 deadbeef 1 1",
               err_timeout, m0_rbusy, m0_rdata, s_rstrb, grant);
    end
    tick(); @(negedge clk);
    tests_run++;
    if (err_timeout !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL timeout_pulse_width: got %b expected 0", err_timeout);
    end
    tick(); @(negedge clk);
    tests_run++;
    if ({m1_rbusy, m1_rdata} !== {1'b0, 32'h1234_5608}) begin
      tests_failed++; $display("[TB] FAIL timeout_m1_served: got rbusy %b rdata %h expected 0 12345608", m1_rbusy, m1_rdata);
    end
`else
    begin
      int cycles;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (err_timeout !== 1'b0 || m0_rbusy !== 1'b1 || m1_rbusy !== 1'b1) bad = 1'b1;
        tick();
      end
      tests_run++;
      if (bad !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL stall_hold: got completion or err pulse expected indefinite WAIT");
      end
      s_rbusy = 1'b0;
      cycles = 0;
      while ((m0_rbusy || m1_rbusy) && cycles < 20) begin
        if (err_timeout !== 1'b0) bad = 1'b1;
        tick(); cycles++;
      end
      @(negedge clk);
      tests_run++;
      if ({m0_rbusy, m1_rbusy, m0_rdata, m1_rdata, bad} !== {2'b00, 32'h1234_5638, 32'h1234_5608, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL stall_release: got busy %b%b rdata %h/%h err_seen %b expected 00 12345638/12345608 0",
                 m0_rbusy, m1_rbusy, m0_rdata, m1_rdata, bad);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    do_reset();
    test_simultaneous();
    test_write_stall();
    test_alternation();
    test_reset_in_wait();
    test_timeout();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
